// File: rtl/aes_dec_pkg.sv
// Shared constants, state encoding and index helper for the AES-128
// decryption round-key store.
package aes_dec_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_SLOTS  = NUM_ROUNDS + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  // Decryption round r uses encryption round key K[NUM_ROUNDS - r].
  function automatic logic [3:0] rev_idx(input logic [3:0] r);
    return 4'(NUM_ROUNDS) - r;
  endfunction

endpackage

// File: rtl/dec_round_key_store_if.sv
// Read bus between the decryption round datapath (master) and the
// round-key store (slave).
interface dec_round_key_store_if #(
  parameter int BLOCK_LENGTH = 128
) ();

  logic                    rd_en;
  logic [3:0]              rd_round;
  logic [BLOCK_LENGTH-1:0] rd_key;
  logic                    rd_valid;
  logic                    rd_err;

  modport master (
    output rd_en, rd_round,
    input  rd_key, rd_valid, rd_err
  );

  modport slave (
    input  rd_en, rd_round,
    output rd_key, rd_valid, rd_err
  );

endinterface

// File: rtl/dec_key_slot_bank.sv
// Round-key register file: one synchronous write port, one registered
// synchronous read port. Storage is not reset; only the read register is.
module dec_key_slot_bank #(
  parameter int BLOCK_LENGTH = 128,
  parameter int DEPTH        = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [3:0]              waddr,
  input  logic [BLOCK_LENGTH-1:0] wdata,
  input  logic                    re,
  input  logic [3:0]              raddr,
  output logic [BLOCK_LENGTH-1:0] rdata
);

  logic [BLOCK_LENGTH-1:0] mem [DEPTH];

  // Capture a round key into its slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dec_round_key_store.sv
// Sequences the AES-128 key generator through rounds 0..10, captures
// K0..K10 into a slot bank and serves them in reverse round order.
module dec_round_key_store
  import aes_dec_pkg::*;
#(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = aes_dec_pkg::NUM_ROUNDS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  input  logic [BLOCK_LENGTH-1:0] cipher_key,
  output logic                    kg_en,
  output logic [3:0]              kg_round,
  output logic [BLOCK_LENGTH-1:0] kg_key,
  input  logic [BLOCK_LENGTH-1:0] kg_current_key,
  output logic                    key_ready,
  output logic                    busy,
  dec_round_key_store_if.slave    rd
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  logic [1:0] state;
  logic [3:0] issue_cnt;
  logic       issue_done;
  logic       cap_valid;
  logic [3:0] cap_ptr;
  logic       bank_we;
  logic       rd_accept;
  logic       rd_bad;

  assign key_ready = (state == READY);
  assign busy      = (state == EXPAND);
  assign kg_en     = busy && !issue_done;
  assign kg_round  = issue_cnt;

  // The generator output lags its request by one cycle, so captures use
  // the delayed pointer; a restart in the same cycle discards the capture.
  assign bank_we   = busy && cap_valid && !load_req;
  assign rd_accept = key_ready && rd.rd_en && (rd.rd_round <= LAST);
  assign rd_bad    = key_ready && rd.rd_en && (rd.rd_round > LAST);

  // Expansion sequencing: issue counter, delayed capture pointer, FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      cap_valid  <= 1'b0;
      cap_ptr    <= '0;
      kg_key     <= '0;
    end else if (load_req) begin
      // Same start action from IDLE, READY, or as a restart mid-EXPAND.
      state      <= EXPAND;
      kg_key     <= cipher_key;
      issue_cnt  <= '0;
      issue_done <= 1'b0;
      cap_valid  <= 1'b0;
      cap_ptr    <= '0;
    end else if (state == EXPAND) begin
      cap_valid <= kg_en;
      cap_ptr   <= issue_cnt;
      if (!issue_done) begin
        if (issue_cnt == LAST) issue_done <= 1'b1;
        else                   issue_cnt  <= issue_cnt + 4'd1;
      end
      if (cap_valid && (cap_ptr == LAST)) state <= READY;
    end else if (state != READY) begin
      state <= IDLE;
    end
  end

  // Read response strobes, one cycle after the sampled request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_err   <= 1'b0;
    end else begin
      rd.rd_valid <= rd_accept;
      rd.rd_err   <= rd_bad;
    end
  end

  dec_key_slot_bank #(
    .BLOCK_LENGTH (BLOCK_LENGTH),
    .DEPTH        (NUM_ROUNDS + 1)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .waddr (cap_ptr),
    .wdata (kg_current_key),
    .re    (rd_accept),
    .raddr (rev_idx(rd.rd_round)),
    .rdata (rd.rd_key)
  );

endmodule

// File: tb/tb_dec_round_key_store.sv
// Bench for dec_round_key_store: behavioural key generator, FIPS-197 key
// schedule reference, and a queue scoreboard for read responses.
module tb_dec_round_key_store;

  localparam int BL = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req;
  logic [BL-1:0] cipher_key;
  logic          kg_en;
  logic [3:0]    kg_round;
  logic [BL-1:0] kg_key;
  logic [BL-1:0] kg_current_key = '0;
  logic          key_ready;
  logic          busy;

  dec_round_key_store_if #(.BLOCK_LENGTH(BL)) rd_if ();

  dec_round_key_store #(.BLOCK_LENGTH(BL), .NUM_ROUNDS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .load_req       (load_req),
    .cipher_key     (cipher_key),
    .kg_en          (kg_en),
    .kg_round       (kg_round),
    .kg_key         (kg_key),
    .kg_current_key (kg_current_key),
    .key_ready      (key_ready),
    .busy           (busy),
    .rd             (rd_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- AES helpers ----------------
  logic [127:0] srow [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    int unsigned  col;
    row = srow[b[7:4]];
    col = 15 - int'(b[3:0]);
    return row[col*8 +: 8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c = 8'h01;
    for (int i = 1; i < r; i++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h1b : 8'h00);
    return c;
  endfunction

  function automatic logic [127:0] gen_next(input logic [127:0] p, input int r);
    logic [31:0] t, a, b, c, d;
    t = subword({p[23:0], p[31:24]}) ^ {rcon(r), 24'h0};
    a = p[127:96] ^ t;
    b = p[95:64] ^ a;
    c = p[63:32] ^ b;
    d = p[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  // Stand-in for the external generator: registers one round key per enabled cycle.
  always @(posedge clk) begin
    if (kg_en) begin
      if (kg_round == 4'd0) kg_current_key <= kg_key;
      else                  kg_current_key <= gen_next(kg_current_key, int'(kg_round));
    end
  end

  // ---------------- Reference model ----------------
  logic [127:0] m_bank [11];
  logic [127:0] m_pend [11];
  logic [127:0] m_rdkey = '0;
  logic [127:0] m_kgkey = '0;
  bit           m_ready = 1'b0;
  int           cd      = 0;   // edges remaining until the expanded set is usable

  // FIPS-197 word recurrence over 44 words.
  task automatic compute_keys(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rcon(i/4), 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  typedef struct {
    int           due;
    bit           v;
    bit           e;
    logic [127:0] key;
  } exp_t;
  exp_t sbq [$];

  // Monitor: compare each due response; flag any response nobody expected.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rd_valid", 128'(rd_if.rd_valid), 128'(e.v));
      chk("rd_err",   128'(rd_if.rd_err),   128'(e.e));
      chk("rd_key",   rd_if.rd_key,         e.key);
    end else if (!rst && (rd_if.rd_valid || rd_if.rd_err)) begin
      chk("unexpected_rd_response", {126'd0, rd_if.rd_valid, rd_if.rd_err}, 128'd0);
    end
  end

  // One cycle of stimulus: check control outputs, drive, predict, advance model.
  task automatic step(input bit ld, input logic [127:0] k, input bit re,
                      input logic [3:0] rr, input bit lit_en, input logic [127:0] lit);
    exp_t e;
    @(negedge clk);
    chk("key_ready", 128'(key_ready), 128'(m_ready));
    chk("busy",      128'(busy),      128'(cd > 0));
    chk("kg_en",     128'(kg_en),     128'(cd >= 2));
    if (cd >= 2) chk("kg_round", 128'(kg_round), 128'(12 - cd));
    if (cd > 0)  chk("kg_key",   kg_key, m_kgkey);
    load_req       = ld;
    cipher_key     = k;
    rd_if.rd_en    = re;
    rd_if.rd_round = rr;
    if (re) begin
      e.due = cyc + 1;
      e.v   = 1'b0;
      e.e   = 1'b0;
      if (m_ready && rr <= 4'd10) begin
        e.v     = 1'b1;
        m_rdkey = lit_en ? lit : m_bank[10 - int'(rr)];
      end else if (m_ready) begin
        e.e = 1'b1;
      end
      e.key = m_rdkey;
      sbq.push_back(e);
    end
    if (ld) begin
      m_kgkey = k;
      compute_keys(k);
      cd      = 12;
      m_ready = 1'b0;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) m_bank[i] = m_pend[i];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 4'd0, 1'b0, '0);
  endtask

  task automatic rd(input logic [3:0] rr);
    step(1'b0, '0, 1'b1, rr, 1'b0, '0);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [127:0] rk;
    rst = 1'b1;
    load_req = 1'b0;
    cipher_key = '0;
    rd_if.rd_en = 1'b0;
    rd_if.rd_round = '0;
    repeat (2) @(negedge clk);
    chk("reset_kg_en",     128'(kg_en),          128'd0);
    chk("reset_kg_round",  128'(kg_round),       128'd0);
    chk("reset_kg_key",    kg_key,               128'd0);
    chk("reset_key_ready", 128'(key_ready),      128'd0);
    chk("reset_busy",      128'(busy),           128'd0);
    chk("reset_rd_key",    rd_if.rd_key,         128'd0);
    chk("reset_rd_valid",  128'(rd_if.rd_valid), 128'd0);
    chk("reset_rd_err",    128'(rd_if.rd_err),   128'd0);
    rst = 1'b0;

    // FIPS-197 expansion; reads before ready are ignored.
    rd(4'd0);
    step(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0);
    idle(11);
    rd(4'd3);
    idle(1);
    step(1'b0, '0, 1'b1, 4'd0,  1'b1, FIPS_K10);
    step(1'b0, '0, 1'b1, 4'd10, 1'b1, FIPS_KEY);
    for (int r = 0; r <= 10; r++) rd(4'(r));
    rd(4'd12);
    idle(2);

    // Read during expansion, then restart with an all-zero key at E6.
    step(1'b1, FIPS_KEY, 1'b0, 4'd0, 1'b0, '0);
    idle(4);
    rd(4'd2);
    step(1'b1, '0, 1'b0, 4'd0, 1'b0, '0);
    idle(12);
    step(1'b0, '0, 1'b1, 4'd0, 1'b1, ZERO_K10);

    // Load and read on the same edge in READY: the read sees the old bank.
    step(1'b1, FIPS_KEY, 1'b1, 4'd0, 1'b1, ZERO_K10);
    rd(4'd1);
    idle(12);
    rd(4'd15);
    rd(4'd10);

    // Asynchronous reset part-way through an expansion.
    step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd0, 1'b0, '0);
    idle(7);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_kg_en",     128'(kg_en),     128'd0);
    chk("midrst_busy",      128'(busy),      128'd0);
    chk("midrst_key_ready", 128'(key_ready), 128'd0);
    chk("midrst_kg_key",    kg_key,          128'd0);
    m_ready = 1'b0;
    cd      = 0;
    m_rdkey = '0;
    m_kgkey = '0;
    @(negedge clk);
    chk("midrst_hold_ready", 128'(key_ready), 128'd0);
    rst = 1'b0;
    rd(4'd0);
    step(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'd0, 1'b0, '0);
    idle(12);
    rd(4'd5);
    rd(4'd0);

    // Randomized traffic: reads, bad indices, loads at arbitrary moments.
    for (int i = 0; i < 500; i++) begin
      bit          ld, re;
      logic [3:0]  rr;
      ld = ($urandom_range(0, 39) == 0);
      rk = {$urandom, $urandom, $urandom, $urandom};
      re = ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      step(ld, rk, re, rr, 1'b0, '0);
    end

    idle(3);
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dec_round_key_store.md
Name: dec_round_key_store

Overview:
- Downstream of the sequential AES-128 decryption key generator.
- On a load request it sequences the generator through rounds 0..10 and captures each round key K0..K10 into an 11-entry bank.
- It then serves keys to the decryption round datapath in reverse order: decryption round r reads K[10-r].
- It also supplies the generator's en, Round_Count and key inputs.

Parameters:
- BLOCK_LENGTH, 128, key/state width in bits.
- NUM_ROUNDS, 10, number of AES rounds; the bank holds NUM_ROUNDS+1 keys.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_req  input  1  single-cycle request to expand cipher_key; sampled on the rising edge.
- cipher_key  input  BLOCK_LENGTH  initial key, valid with load_req.
- kg_en  output  1  enable to the key generator.
- kg_round  output  4  Round_Count to the key generator.
- kg_key  output  BLOCK_LENGTH  latched initial key to the key generator.
- kg_current_key  input  BLOCK_LENGTH  generator's registered round-key output.
- key_ready  output  1  high while the bank holds a complete K0..K10 set.
- busy  output  1  high during expansion.
- rd_en  input  1  read strobe from the decryption datapath.
- rd_round  input  4  decryption round index, 0..10.
- rd_key  output  BLOCK_LENGTH  round key K[NUM_ROUNDS-rd_round], registered.
- rd_valid  output  1  rd_key valid pulse.
- rd_err  output  1  pulse: rd_round > NUM_ROUNDS.

Behaviour:
- Reset (async, rst=1):
  - Outputs: kg_en=0, kg_round=0, kg_key=0, key_ready=0, busy=0, rd_key=0, rd_valid=0, rd_err=0.
  - State IDLE; issue counter and capture pointer = 0.
  - Bank contents are don't-care and are not cleared.
- FSM states:
  - IDLE:
    - load_req → latch cipher_key into kg_key, issue counter = 0, go to EXPAND.
  - EXPAND:
    - kg_en=1; kg_round = issue counter, stepping 0..10 one per cycle.
    - The generator registers the key one cycle after each request, so a 1-cycle-delayed capture pointer writes kg_current_key into slot[ptr].
    - Capture of slot 10 occurs on the cycle after kg_round=10 is issued; the FSM then moves to READY.
    - kg_en=0 once the issue counter has passed 10, so there is no extra enable.
  - READY:
    - key_ready=1, kg_en=0.
    - load_req → same action as from IDLE; key_ready falls on the same edge.
- Latency: load_req sampled at edge E0 → kg_round=0 issued E0..E1 → slot 10 captured and key_ready=1 after edge E12. This is 12 cycles.
- busy=1 exactly while in EXPAND.
- Reads:
  - Accepted only when key_ready=1 at the sampling edge.
  - Next cycle: rd_key = slot[10-rd_round] and rd_valid=1, a 1-cycle pulse per accepted read.
  - Back-to-back reads every cycle are allowed.
  - rd_key holds its last value when no read is accepted.
- rd_en while key_ready=0 is ignored: rd_valid=0, rd_err=0, rd_key unchanged.
- rd_round 11..15 with key_ready=1 gives rd_err=1 for one cycle, rd_valid=0, rd_key unchanged.
- load_req during EXPAND:
  - Restarts the expansion from round 0 with the new cipher_key.
  - Any in-flight capture of the old sequence is discarded: the pointer resets and the delayed-capture valid is cleared.
- Simultaneous load_req and rd_en in READY:
  - The read is served from the old bank (rd_valid=1 next cycle).
  - The expansion then starts and key_ready drops.
- Reset mid-EXPAND: immediate return to IDLE, kg_en=0, key_ready=0.
- Counters are 4 bits; the issue counter saturates at 10 and never wraps.

Decomposition:
- Shared package aes_dec_pkg holds:
  - NUM_ROUNDS and KEY_SLOTS (=NUM_ROUNDS+1).
  - FSM state encoding {IDLE, EXPAND, READY}.
  - The reversed-index function rev_idx(r) = NUM_ROUNDS-r.
- One sub-module, dec_key_slot_bank: an 11×BLOCK_LENGTH register file with one synchronous write port and one synchronous read port. Its read reg drives rd_key.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, load_req at E0 → key_ready rises after E12; kg_en high for exactly 11 cycles with kg_round 0..10 in order.
- After the expansion above, read rd_round=0 → next cycle rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and rd_valid=1.
- Same bank, read rd_round=10 → rd_key=2b7e151628aed2a6abf7158809cf4f3c.
- Reads rd_round=0..10 on consecutive cycles → 11 rd_valid pulses with keys K10..K0. Then rd_round=12 → rd_err pulse, rd_valid=0, rd_key unchanged.
- rd_en at cycle E5 during expansion → no rd_valid. load_req with all-zero key at E6 → expansion restarts; key_ready after E6+12; rd_round=0 returns b4ef5bcb3e92e21123e951cf6f8f188e.
- Assert rst at E7 of an expansion → kg_en=0 and busy=0 immediately; key_ready stays 0; a subsequent load completes normally.
